// File: rtl/uart_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_pkg : shared types and constants for the UART receive controller
// Rev 1.0
// ------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    RX_RST   = 3'd0,
    RUN      = 3'd1,
    AB_SYNC  = 3'd2,
    AB_MEAS  = 3'd3,
    AB_APPLY = 3'd4
  } rx_ctrl_state_t;

  typedef logic [15:0] baud_div_t;

  localparam int RX_RST_CYCLES = 2;
  localparam int AB_SYNC_EDGES = 4;

  // Eight bit times were measured; divide, clamp to 16 bits, never return 0.
  function automatic baud_div_t ab_divisor(input logic [23:0] cnt);
    logic [20:0] q;
    q = cnt[23:3];
    if (q == 21'd0) return 16'd1;
    if (q > 21'h00FFFF) return 16'hFFFF;
    return q[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_rx_fifo : synchronous receive FIFO, registered flags, reset-cleared storage
// Rev 1.0
// ------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_rx_ctrl : UART receiver control, divisor/reset sequencing, byte FIFO
// Auto-baud measurement is built only with UART_RX_AUTOBAUD_EN defined. Rev 1.0
// ------------------------------------------------------------------
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter baud_div_t   RST_BAUD   = 16'd434,
  parameter logic [23:0] AB_TIMEOUT = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cfg_baud,
  input  logic        cfg_wr,
  input  logic        ab_start,
  output logic        ab_done,
  output logic        ab_err,
  output logic [15:0] rx_baudrate,
  output logic        rx_rst,
  input  logic        rx_line,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow,
  input  logic        ovf_clr,
  output logic        busy
);

  rx_ctrl_state_t state;
  rx_ctrl_state_t state_nxt;
  logic [1:0]     rst_cnt;
  logic           rst_cnt_done;
  baud_div_t      baud;
  logic           cfg_take;
  logic           push_req;
  logic           pop;
  logic           full;
  logic           empty;
  logic           drop;
  logic           ovf;

  assign rst_cnt_done = (rst_cnt == 2'(RX_RST_CYCLES - 1));
  assign cfg_take     = (state == RUN) && cfg_wr && (cfg_baud != 16'd0);
  assign push_req     = rx_valid && (state == RUN);
  assign pop          = out_valid && out_ready;
  assign drop         = push_req && full && !pop;

  assign rx_rst      = (state != RUN);
  assign busy        = (state != RUN);
  assign rx_baudrate = baud;
  assign out_valid   = !empty;
  assign overflow    = ovf;

`ifdef UART_RX_AUTOBAUD_EN
  logic [2:0]  line_sync;
  logic        fall;
  logic        ab_take;
  logic        ab_tmo;
  logic        meas_last;
  logic [23:0] meas_cnt;
  logic [23:0] tmo_cnt;
  logic [1:0]  edge_cnt;
  logic        err;

  // [0],[1] synchronise the line; [2] holds the prior value for edge detect.
  assign fall      = line_sync[2] & ~line_sync[1];
  assign ab_take   = (state == RUN) && ab_start && !cfg_take;
  assign ab_tmo    = (tmo_cnt == AB_TIMEOUT - 24'd1);
  assign meas_last = fall && (edge_cnt == 2'(AB_SYNC_EDGES - 1));
  assign ab_done   = (state == AB_APPLY);
  assign ab_err    = err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_sync <= 3'b111;
      meas_cnt  <= '0;
      tmo_cnt   <= '0;
      edge_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      line_sync <= {line_sync[1:0], rx_line};
      if (ab_take) begin
        tmo_cnt <= '0;
        err     <= 1'b0;
      end else if (state == AB_SYNC || state == AB_MEAS) begin
        tmo_cnt <= tmo_cnt + 24'd1;
        if (ab_tmo) err <= 1'b1;
      end
      // Counter reads 1 in the first cycle after the start edge, so it
      // holds the exact edge-to-edge cycle distance on the final edge.
      if (state == AB_SYNC) begin
        meas_cnt <= 24'd1;
        edge_cnt <= '0;
      end else if (state == AB_MEAS && !meas_last) begin
        meas_cnt <= meas_cnt + 24'd1;
        if (fall) edge_cnt <= edge_cnt + 2'd1;
      end
    end
  end
`else
  logic unused_ab;
  assign unused_ab = ^{ab_start, rx_line, AB_TIMEOUT};
  assign ab_done   = 1'b0;
  assign ab_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RX_RST;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RX_RST: if (rst_cnt_done) state_nxt = RUN;
      RUN: begin
        if (cfg_take) state_nxt = RX_RST;
`ifdef UART_RX_AUTOBAUD_EN
        else if (ab_take) state_nxt = AB_SYNC;
`endif
      end
`ifdef UART_RX_AUTOBAUD_EN
      AB_SYNC: begin
        if (ab_tmo)    state_nxt = RX_RST;
        else if (fall) state_nxt = AB_MEAS;
      end
      AB_MEAS: begin
        if (ab_tmo)         state_nxt = RX_RST;
        else if (meas_last) state_nxt = AB_APPLY;
      end
      AB_APPLY: state_nxt = RX_RST;
`endif
      default: state_nxt = RX_RST;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_cnt <= '0;
    end else if (state == RX_RST && !rst_cnt_done) begin
      rst_cnt <= rst_cnt + 2'd1;
    end else begin
      rst_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud <= RST_BAUD;
    end else if (cfg_take) begin
      baud <= cfg_baud;
`ifdef UART_RX_AUTOBAUD_EN
    end else if (state == AB_APPLY) begin
      baud <= ab_divisor(meas_cnt);
`endif
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf <= 1'b0;
    else     ovf <= drop | (ovf & ~ovf_clr);
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .wdata (rx_data),
    .rdata (out_data),
    .full  (full),
    .empty (empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_uart_rx_ctrl : table-driven and scoreboard bench for uart_rx_ctrl
// Rev 1.0
// ------------------------------------------------------------------
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;
  localparam int ABT   = 3000;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic [15:0] cfg_baud  = '0;
  logic        cfg_wr    = 1'b0;
  logic        ab_start  = 1'b0;
  logic        rx_line   = 1'b1;
  logic [7:0]  rx_data   = '0;
  logic        rx_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic        ovf_clr   = 1'b0;
  logic        ab_done, ab_err, rx_rst, out_valid, overflow, busy;
  logic [15:0] rx_baudrate;
  logic [7:0]  out_data;

  int         errors      = 0;
  int         checks      = 0;
  int         ab_done_cnt = 0;
  logic       m_ovf       = 1'b0;
  logic [7:0] sb[$];

  typedef struct {
    logic [15:0] baud;
    logic [15:0] exp_baud;
    logic        exp_rst;
  } cfg_vec_t;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       ready;
  } rx_vec_t;

  cfg_vec_t cv[4];
  rx_vec_t  rv[24];

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .RST_BAUD   (16'd434),
    .AB_TIMEOUT (24'(ABT))
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_baud    (cfg_baud),
    .cfg_wr      (cfg_wr),
    .ab_start    (ab_start),
    .ab_done     (ab_done),
    .ab_err      (ab_err),
    .rx_baudrate (rx_baudrate),
    .rx_rst      (rx_rst),
    .rx_line     (rx_line),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every handshake on the output stream pops one expected byte.
  always @(negedge clk) begin
    if (!rst && ab_done) ab_done_cnt++;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h expected no data", out_data);
      end else begin
        check("out_data", out_data, sb.pop_front());
      end
    end
  end

  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic in_run);
    logic acc;
    rx_valid  = v;
    rx_data   = d;
    out_ready = r;
    acc = in_run && ((sb.size() < DEPTH) || (r && sb.size() > 0));
    if (v && acc) sb.push_back(d);
    if (v && in_run && !acc) m_ovf = 1'b1;
    tick();
    rx_valid = 1'b0;
    check("overflow", overflow, m_ovf);
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    check("drain_left", sb.size(), 0);
    check("drain_empty", out_valid, 1'b0);
  endtask

  task automatic clear_ovf();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    m_ovf   = 1'b0;
    check("ovf_clr", overflow, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] b, input int cpb);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_line = f[k];
      repeat (cpb) tick();
    end
    rx_line = 1'b1;
  endtask

  initial begin
    cv[0] = '{baud: 16'd27,  exp_baud: 16'd27,  exp_rst: 1'b1};
    cv[1] = '{baud: 16'd0,   exp_baud: 16'd27,  exp_rst: 1'b0};
    cv[2] = '{baud: 16'd1,   exp_baud: 16'd1,   exp_rst: 1'b1};
    cv[3] = '{baud: 16'd434, exp_baud: 16'd434, exp_rst: 1'b1};
    for (int i = 0; i < 24; i++) begin
      rv[i].valid = ((i % 3) != 2);
      rv[i].data  = 8'(8'h40 + i);
      rv[i].ready = ((i % 5) >= 2);
    end

    // Reset values, then the two-cycle receiver reset after release
    repeat (3) tick();
    check("rst_baud", rx_baudrate, 16'd434);
    check("rst_rx_rst", rx_rst, 1'b1);
    check("rst_busy", busy, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_overflow", overflow, 1'b0);
    check("rst_ab_done", ab_done, 1'b0);
    check("rst_ab_err", ab_err, 1'b0);
    rst = 1'b0;
    check("rel_rx_rst_c1", rx_rst, 1'b1);
    tick();
    check("rel_rx_rst_c2", rx_rst, 1'b1);
    tick();
    check("rel_rx_rst_off", rx_rst, 1'b0);
    check("rel_busy", busy, 1'b0);

    // First-byte latency and output stability without ready
    sb.push_back(8'h5A);
    rx_data  = 8'h5A;
    rx_valid = 1'b1;
    #1;
    check("lat_same_cycle", out_valid, 1'b0);
    tick();
    rx_valid = 1'b0;
    check("lat_next_valid", out_valid, 1'b1);
    check("lat_next_data", out_data, 8'h5A);
    tick();
    check("hold_data", out_data, 8'h5A);
    drain();

    // Divisor writes from the table
    for (int i = 0; i < 4; i++) begin
      cfg_baud = cv[i].baud;
      cfg_wr   = 1'b1;
      tick();
      cfg_wr = 1'b0;
      check("cfg_baud", rx_baudrate, cv[i].exp_baud);
      check("cfg_rst_c1", rx_rst, cv[i].exp_rst);
      tick();
      check("cfg_rst_c2", rx_rst, cv[i].exp_rst);
      tick();
      check("cfg_busy", busy, 1'b0);
    end

    // FIFO survives a divisor write; writes and bytes outside RUN are ignored
    step(1'b1, 8'hA1, 1'b0, 1'b1);
    step(1'b1, 8'hA2, 1'b0, 1'b1);
    cfg_baud = 16'd55;
    cfg_wr   = 1'b1;
    tick();
    cfg_baud = 16'd99;
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    cfg_wr = 1'b0;
    check("cfg_outside_run", rx_baudrate, 16'd55);
    tick();
    check("cfg_back_run", busy, 1'b0);
    check("fifo_kept", out_valid, 1'b1);
    drain();

    // Mixed push/pop stream with pointer wrap
    for (int i = 0; i < 24; i++) step(rv[i].valid, rv[i].data, rv[i].ready, 1'b1);
    drain();

    // Overflow at depth, clear, clear-vs-drop, and push with simultaneous pop when full
    for (int b = 1; b <= 9; b++) step(1'b1, 8'(b), 1'b0, 1'b1);
    clear_ovf();
    ovf_clr = 1'b1;
    step(1'b1, 8'hAA, 1'b0, 1'b1);
    ovf_clr = 1'b0;
    clear_ovf();
    step(1'b1, 8'h77, 1'b1, 1'b1);
    step(1'b1, 8'hBB, 1'b0, 1'b1);
    drain();
    clear_ovf();

`ifdef UART_RX_AUTOBAUD_EN
    ab_start = 1'b1;
    tick();
    ab_start = 1'b0;
    check("ab_busy", busy, 1'b1);
    check("ab_rx_rst", rx_rst, 1'b1);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    repeat (20) tick();
    send_frame(8'h55, 100);
    for (int n = 0; n < 200 && busy; n++) tick();
    check("ab_baud", rx_baudrate, 16'd100);
    check("ab_done_pulses", ab_done_cnt, 1);
    check("ab_run", busy, 1'b0);
    check("ab_no_byte", out_valid, 1'b0);

    ab_start = 1'b1;
    tick();
    ab_start = 1'b0;
    for (int n = 0; n < ABT + 100 && busy; n++) tick();
    check("ab_tmo_err", ab_err, 1'b1);
    check("ab_tmo_baud", rx_baudrate, 16'd100);
    check("ab_tmo_run", busy, 1'b0);

    ab_start = 1'b1;
    tick();
    ab_start = 1'b0;
    check("ab_err_clear", ab_err, 1'b0);
    rx_line = 1'b0;
    repeat (50) tick();
    rx_line = 1'b1;
    repeat (20) tick();
`else
    ab_start = 1'b1;
    tick();
    ab_start = 1'b0;
    check("noab_busy", busy, 1'b0);
    send_frame(8'h55, 10);
    check("noab_err", ab_err, 1'b0);
    check("noab_baud", rx_baudrate, 16'd55);
`endif

    // Asynchronous reset mid-cycle discards state immediately
    step(1'b1, 8'hC3, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    m_ovf = 1'b0;
    check("arst_valid", out_valid, 1'b0);
    check("arst_baud", rx_baudrate, 16'd434);
    check("arst_rx_rst", rx_rst, 1'b1);
    check("arst_ab_err", ab_err, 1'b0);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("arst_run", busy, 1'b0);
`ifdef UART_RX_AUTOBAUD_EN
    check("arst_no_ab_done", ab_done_cnt, 1);
`else
    check("noab_done", ab_done_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
